// File: rtl/bellman_sched.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// bellman_sched
//
// Purpose:
//   Scheduler/arbiter in front of the Bellman relaxation engine. Source-node run
//   requests are queued in a small FIFO and launched one at a time: a one-cycle
//   start pulse carries the source to the engine, then the block waits for the
//   engine's done flag under a watchdog and reports the outcome. It also arbitrates
//   host writes to the adjacency matrix. Writes are granted only when no run is in
//   flight, so the matrix stays stable for a whole engine pass.
//
// Parameters:
//   NODES    node count (legal sources 0..NODES-1; not range-checked here)
//   SRC_W    width of a source-node index
//   QDEPTH   request FIFO depth, power of two, >= 2
//   TIMEOUT  WAIT cycles before a run is abandoned, >= 2
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_req_valid    host offers a run request
//   i_req_src      requested source node
//   o_req_ready    FIFO accepts (handshake = valid & ready)
//   i_upd_valid    host wants to write an adjacency-matrix edge
//   o_upd_ready    write granted this cycle
//   o_bf_start     one-cycle start pulse to the engine
//   o_bf_src       source for the engine, valid with o_bf_start
//   i_bf_done      engine done flag (level, cleared by the engine on start)
//   o_res_valid    one-cycle pulse: a run finished
//   o_res_src      source of the finished run, valid with o_res_valid
//   o_res_timeout  with o_res_valid: 1 = watchdog expired, 0 = normal done
//   o_busy         a run is in LAUNCH, WAIT or REPORT
// -----------------------------------------------------------------------------
module bellman_sched #(
    parameter int NODES   = 16,
    parameter int SRC_W   = 7,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    input  logic [SRC_W-1:0] i_req_src,
    output logic             o_req_ready,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    output logic             o_bf_start,
    output logic [SRC_W-1:0] o_bf_src,
    input  logic             i_bf_done,
    output logic             o_res_valid,
    output logic [SRC_W-1:0] o_res_src,
    output logic             o_res_timeout,
    output logic             o_busy
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] QFULL   = CNT_W'(QDEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    // Elaboration-time parameter sanity checks
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("bellman_sched: QDEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("bellman_sched: TIMEOUT must be >= 2");
    end
    if (NODES < 1 || NODES > (1 << SRC_W)) begin : g_bad_nodes
        $error("bellman_sched: NODES must fit in SRC_W bits");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [SRC_W-1:0] r_mem [QDEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WD_W-1:0]  r_wdog;
    logic             r_last_launch;  // 1: last IDLE grant went to a launch
    logic [SRC_W-1:0] r_src;          // source of the run in flight
    logic             r_timeout;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic w_req_ready;
    logic w_push;
    logic w_pop;
    logic w_idle;
    logic w_have;
    logic w_upd_grant;
    logic w_done_ok;

    // Ready comes from the registered count only: no bypass when full.
    assign w_req_ready = !i_reset && (r_count < QFULL);
    assign w_push      = i_req_valid && w_req_ready;
    assign w_pop       = (r_state == S_LAUNCH);
    assign w_idle      = (r_state == S_IDLE);
    assign w_have      = (r_count != '0);

    // With both a queued request and a pending update, the grant alternates;
    // an update alone is always granted. A launch decision never grants.
    assign w_upd_grant = w_idle && i_upd_valid && (!w_have || r_last_launch);

    // The first WAIT cycle (watchdog 0) may still see the previous run's done.
    assign w_done_ok   = (r_state == S_WAIT) && i_bf_done && (r_wdog != '0);

    // -------------------------------------------------------------------------
    // FIFO storage (no reset needed; occupancy is tracked by r_count)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_req_src;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers, FSM, watchdog
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_wdog        <= '0;
            r_last_launch <= 1'b1;
            r_src         <= '0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_upd_grant) begin
                        r_last_launch <= 1'b0;
                    end else if (w_have) begin
                        r_last_launch <= 1'b1;
                        r_src         <= r_mem[r_rptr];
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    // Done takes priority over a simultaneous expiry.
                    if (w_done_ok) begin
                        r_timeout <= 1'b0;
                        r_state   <= S_REPORT;
                    end else if (r_wdog == WD_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all forced low while reset is asserted
    // -------------------------------------------------------------------------
    assign o_req_ready   = w_req_ready;
    assign o_upd_ready   = !i_reset && w_upd_grant;
    assign o_bf_start    = !i_reset && (r_state == S_LAUNCH);
    assign o_bf_src      = o_bf_start ? r_src : '0;
    assign o_res_valid   = !i_reset && (r_state == S_REPORT);
    assign o_res_src     = o_res_valid ? r_src : '0;
    assign o_res_timeout = o_res_valid && r_timeout;
    assign o_busy        = !i_reset && (r_state != S_IDLE);

endmodule

// File: tb/tb_bellman_sched.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_bellman_sched
//
// Directed bench for bellman_sched (QDEPTH=4, TIMEOUT=64). Inputs change at
// posedge+3, outputs are sampled one time unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_bellman_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [6:0] req_src;
    logic       req_ready;
    logic       upd_valid;
    logic       upd_ready;
    logic       bf_start;
    logic [6:0] bf_src;
    logic       bf_done;
    logic       res_valid;
    logic [6:0] res_src;
    logic       res_timeout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bellman_sched #(
        .NODES  (16),
        .SRC_W  (7),
        .QDEPTH (4),
        .TIMEOUT(64)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .i_req_src    (req_src),
        .o_req_ready  (req_ready),
        .i_upd_valid  (upd_valid),
        .o_upd_ready  (upd_ready),
        .o_bf_start   (bf_start),
        .o_bf_src     (bf_src),
        .i_bf_done    (bf_done),
        .o_res_valid  (res_valid),
        .o_res_src    (res_src),
        .o_res_timeout(res_timeout),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        while (!bf_start && n < lim) begin
            cyc();
            #1;
            n++;
        end
        chk("bf_start_seen", 32'(bf_start), 32'd1);
    endtask

    // Caller sets bf_done first; waits for the report and checks it.
    task automatic finish_run(input logic [6:0] src, input logic exp_to, input int lim);
        int n       = 0;
        int upd_bad = 0;
        while (!res_valid && n < lim) begin
            if (upd_ready) upd_bad++;
            cyc();
            #1;
            n++;
        end
        if (upd_ready) upd_bad++;
        chk("res_seen", 32'(res_valid), 32'd1);
        chk("res_src", 32'(res_src), 32'(src));
        chk("res_timeout", 32'(res_timeout), 32'(exp_to));
        chk("upd_blocked_busy", 32'(upd_bad), 32'd0);
    endtask

    task automatic run_one(input logic [6:0] src);
        bf_done = 1'b0;
        wait_start(10);
        chk("bf_src_order", 32'(bf_src), 32'(src));
        cyc();
        #1;
        cyc();
        bf_done = 1'b1;
        #1;
        finish_run(src, 1'b0, 5);
        bf_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed still running, required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // ---------------- reset: everything forced low ----------------
        reset     = 1'b1;
        req_valid = 1'b1;
        req_src   = 7'd99;
        upd_valid = 1'b1;
        bf_done   = 1'b0;
        cyc(); #1;
        cyc(); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_bf_start", 32'(bf_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        reset = 1'b0; req_valid = 1'b0; upd_valid = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // ---------------- 1: single run, latency ----------------
        cyc(); req_valid = 1'b1; req_src = 7'd3; #1;
        chk("t1_handshake", 32'(req_ready), 32'd1);
        cyc(); req_valid = 1'b0; #1;
        chk("t1_no_start_t1", 32'(bf_start), 32'd0);
        chk("t1_idle_t1", 32'(busy), 32'd0);
        cyc(); #1;
        chk("t1_start_t2", 32'(bf_start), 32'd1);
        chk("t1_bf_src", 32'(bf_src), 32'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 20) bf_done = 1'b1;
            #1;
            chk("t1_no_early_res", 32'(res_valid | bf_start), 32'd0);
        end
        cyc(); #1;
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_src", 32'(res_src), 32'd3);
        chk("t1_res_timeout", 32'(res_timeout), 32'd0);
        bf_done = 1'b0;
        cyc(); #1;
        chk("t1_res_pulse", 32'(res_valid), 32'd0);
        chk("t1_back_idle", 32'(busy), 32'd0);

        // ---------------- 2: FIFO full, order ----------------
        cyc(); req_valid = 1'b1; req_src = 7'd1; #1;
        chk("t2_push1", 32'(req_ready), 32'd1);
        cyc(); req_valid = 1'b0; #1;
        wait_start(5);
        chk("t2_src1", 32'(bf_src), 32'd1);
        for (int i = 5; i <= 8; i++) begin
            cyc(); req_valid = 1'b1; req_src = 7'(i); #1;
            chk("t2_push_ready", 32'(req_ready), 32'd1);
        end
        cyc(); req_src = 7'd9; #1;
        chk("t2_full", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t2_full_hold", 32'(req_ready), 32'd0);
        end
        cyc(); bf_done = 1'b1; #1;
        chk("t2_full_hold_d", 32'(req_ready), 32'd0);
        cyc(); bf_done = 1'b0; #1;
        chk("t2_res1_valid", 32'(res_valid), 32'd1);
        chk("t2_res1_src", 32'(res_src), 32'd1);
        chk("t2_full_report", 32'(req_ready), 32'd0);
        cyc(); #1;
        chk("t2_full_idle", 32'(req_ready), 32'd0);
        chk("t2_idle_no_start", 32'(bf_start), 32'd0);
        cyc(); #1;
        chk("t2_launch5", 32'(bf_start), 32'd1);
        chk("t2_src5", 32'(bf_src), 32'd5);
        chk("t2_no_bypass", 32'(req_ready), 32'd0);
        cyc(); #1;
        chk("t2_ready_after_pop", 32'(req_ready), 32'd1);
        cyc(); req_valid = 1'b0; bf_done = 1'b1; #1;
        finish_run(7'd5, 1'b0, 5);
        bf_done = 1'b0;
        run_one(7'd6);
        run_one(7'd7);
        run_one(7'd8);
        run_one(7'd9);

        // ---------------- 3: update/launch alternation ----------------
        cyc(); upd_valid = 1'b1; #1;
        chk("t3_upd_only", 32'(upd_ready), 32'd1);
        cyc(); req_valid = 1'b1; req_src = 7'd10; #1;
        chk("t3_upd_empty", 32'(upd_ready), 32'd1);
        chk("t3_push10", 32'(req_ready), 32'd1);
        cyc(); req_src = 7'd11; #1;
        chk("t3_launch_wins_10", 32'(upd_ready), 32'd0);
        chk("t3_decide_idle", 32'(busy), 32'd0);
        cyc(); req_src = 7'd12; #1;
        chk("t3_start10", 32'(bf_start), 32'd1);
        chk("t3_src10", 32'(bf_src), 32'd10);
        chk("t3_upd_launch", 32'(upd_ready), 32'd0);
        cyc(); req_valid = 1'b0; #1;
        chk("t3_upd_wait", 32'(upd_ready), 32'd0);
        cyc(); bf_done = 1'b1; #1;
        finish_run(7'd10, 1'b0, 5);
        bf_done = 1'b0;
        cyc(); #1;
        chk("t3_upd_wins_2", 32'(upd_ready), 32'd1);
        chk("t3_no_start_2", 32'(bf_start), 32'd0);
        cyc(); #1;
        chk("t3_launch_wins_11", 32'(upd_ready), 32'd0);
        cyc(); #1;
        chk("t3_start11", 32'(bf_start), 32'd1);
        chk("t3_src11", 32'(bf_src), 32'd11);
        cyc(); #1;
        cyc(); bf_done = 1'b1; #1;
        finish_run(7'd11, 1'b0, 5);
        bf_done = 1'b0;
        cyc(); #1;
        chk("t3_upd_wins_3", 32'(upd_ready), 32'd1);
        cyc(); #1;
        chk("t3_launch_wins_12", 32'(upd_ready), 32'd0);
        cyc(); #1;
        chk("t3_start12", 32'(bf_start), 32'd1);
        chk("t3_src12", 32'(bf_src), 32'd12);
        cyc(); #1;
        cyc(); bf_done = 1'b1; #1;
        finish_run(7'd12, 1'b0, 5);
        bf_done = 1'b0;
        cyc(); #1;
        chk("t3_upd_empty_end", 32'(upd_ready), 32'd1);
        chk("t3_idle_end", 32'(busy), 32'd0);

        // ---------------- 4: watchdog expiry ----------------
        cyc(); upd_valid = 1'b0; req_valid = 1'b1; req_src = 7'd20; #1;
        chk("t4_push20", 32'(req_ready), 32'd1);
        cyc(); req_src = 7'd21; #1;
        chk("t4_decide", 32'(bf_start), 32'd0);
        cyc(); req_valid = 1'b0; #1;
        chk("t4_start20", 32'(bf_start), 32'd1);
        chk("t4_src20", 32'(bf_src), 32'd20);
        for (int k = 1; k <= 65; k++) begin
            cyc(); #1;
            if (k < 65) begin
                chk("t4_no_early_res", 32'(res_valid), 32'd0);
            end else begin
                chk("t4_res_at_64", 32'(res_valid), 32'd1);
                chk("t4_res_src", 32'(res_src), 32'd20);
                chk("t4_timeout", 32'(res_timeout), 32'd1);
            end
        end
        cyc(); #1;
        chk("t4_idle_after_to", 32'(bf_start), 32'd0);
        cyc(); #1;
        chk("t4_start21", 32'(bf_start), 32'd1);
        chk("t4_src21", 32'(bf_src), 32'd21);
        cyc(); #1;
        cyc(); bf_done = 1'b1; #1;
        finish_run(7'd21, 1'b0, 5);

        // ---------------- 5: stale done ignored ----------------
        cyc(); req_valid = 1'b1; req_src = 7'd30; #1;
        chk("t5_push30", 32'(req_ready), 32'd1);
        cyc(); req_valid = 1'b0; #1;
        chk("t5_decide", 32'(bf_start), 32'd0);
        cyc(); #1;
        chk("t5_start30", 32'(bf_start), 32'd1);
        chk("t5_src30", 32'(bf_src), 32'd30);
        cyc(); #1;
        chk("t5_first_wait", 32'(res_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(); bf_done = 1'b0; #1;
            chk("t5_stale_done", 32'(res_valid), 32'd0);
        end
        cyc(); bf_done = 1'b1; #1;
        chk("t5_done_cycle", 32'(res_valid), 32'd0);
        cyc(); #1;
        chk("t5_res_valid", 32'(res_valid), 32'd1);
        chk("t5_res_src", 32'(res_src), 32'd30);
        chk("t5_res_timeout", 32'(res_timeout), 32'd0);
        bf_done = 1'b0;

        // ---------------- 6: reset mid-run flushes ----------------
        cyc(); req_valid = 1'b1; req_src = 7'd40; #1;
        cyc(); req_src = 7'd41; #1;
        cyc(); req_src = 7'd42; #1;
        chk("t6_start40", 32'(bf_start), 32'd1);
        chk("t6_src40", 32'(bf_src), 32'd40);
        cyc(); req_valid = 1'b0; #1;
        chk("t6_busy_wait", 32'(busy), 32'd1);
        cyc(); reset = 1'b1; upd_valid = 1'b1; #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_upd_ready", 32'(upd_ready), 32'd0);
        cyc(); reset = 1'b0; upd_valid = 1'b0; bf_done = 1'b1; #1;
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        chk("t6_no_res", 32'(res_valid), 32'd0);
        chk("t6_no_start", 32'(bf_start), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("t6_flushed", 32'({busy, bf_start, res_valid}), 32'd0);
        end
        bf_done = 1'b0;
        cyc(); req_valid = 1'b1; req_src = 7'd50; #1;
        cyc(); req_valid = 1'b0; #1;
        wait_start(5);
        chk("t6_src50", 32'(bf_src), 32'd50);
        cyc(); #1;
        cyc(); bf_done = 1'b1; #1;
        finish_run(7'd50, 1'b0, 5);
        bf_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
